reg_file_sb: RTL and testbench



---
 rtl/reg_file_sb.sv | 74 +++++++
 tb/tb_reg_file_sb.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with a pending-write scoreboard for RAW stall detection.
//
// Ports:
//   clk, rst_n                     core clock (rising edge), asynchronous active-low reset
//   rs1_addr/rs1_data              read port 1 (combinational)
//   rs2_addr/rs2_data              read port 2 (combinational)
//   reg_write, rd_addr, write_data write-back sink
//   issue_valid, issue_wr, issue_rd,
//   issue_uses_rs1, issue_uses_rs2 decode issue request
//   stall                          RAW hazard, decode must hold
//   pending_cnt                    number of registers with a write in flight
//
// Optional build macro REG_BYPASS_EN: forwards write_data to the read ports and
// ignores the pending bit of the register being written this cycle.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              issue_valid,
  input  logic              issue_wr,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_uses_rs1,
  input  logic              issue_uses_rs2,
  output logic              stall,
  output logic [ADDR_W:0]   pending_cnt
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending, pending_nxt, wb_mask, set_mask, busy;
  logic [ADDR_W:0]     cnt_nxt;
  logic                wb_en, accept;
  assign wb_en   = reg_write && rd_addr != '0;
  assign wb_mask = wb_en ? (NUM_REGS'(1) << rd_addr) : '0;
`ifdef REG_BYPASS_EN
  // A register written this cycle is already resolved for the reader.
  assign busy     = pending & ~wb_mask;
  assign rs1_data = rs1_addr == '0 ? '0 : (wb_en && rd_addr == rs1_addr) ? write_data : regs[rs1_addr];
  assign rs2_data = rs2_addr == '0 ? '0 : (wb_en && rd_addr == rs2_addr) ? write_data : regs[rs2_addr];
`else
  assign busy     = pending;
  assign rs1_data = rs1_addr == '0 ? '0 : regs[rs1_addr];
  assign rs2_data = rs2_addr == '0 ? '0 : regs[rs2_addr];
`endif
  assign stall    = issue_valid && ((issue_uses_rs1 && busy[rs1_addr]) || (issue_uses_rs2 && busy[rs2_addr]));
  assign accept   = issue_valid && !stall;
  assign set_mask = (accept && issue_wr && issue_rd != '0) ? (NUM_REGS'(1) << issue_rd) : '0;
  // Set after clear: a new producer issued in the write-back cycle keeps ownership.
  assign pending_nxt = ((pending & ~wb_mask) | set_mask) & ~NUM_REGS'(1);
  // The count register is loaded from the next pending state so it always matches pending.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) cnt_nxt = cnt_nxt + (ADDR_W+1)'(pending_nxt[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      if (wb_en) regs[rd_addr] <= write_data;
      pending     <= pending_nxt;
      pending_cnt <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb.
module tb_reg_file_sb;
  logic        clk = 0, rst_n = 0;
  logic [4:0]  rs1_addr = 0, rs2_addr = 0, rd_addr = 0, issue_rd = 0;
  logic [31:0] rs1_data, rs2_data, write_data = 0;
  logic        reg_write = 0, issue_valid = 0, issue_wr = 0, issue_uses_rs1 = 0, issue_uses_rs2 = 0;
  logic        stall;
  logic [5:0]  pending_cnt;
  int          checks = 0, failures = 0;
  bit          byp;

  reg_file_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .reg_write(reg_write), .rd_addr(rd_addr), .write_data(write_data),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
    .issue_uses_rs1(issue_uses_rs1), .issue_uses_rs2(issue_uses_rs2),
    .stall(stall), .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_wr = 1; issue_rd = rd; issue_uses_rs1 = 0; issue_uses_rs2 = 0;
  endtask

  task automatic idle();
    issue_valid = 0; issue_wr = 0; issue_uses_rs1 = 0; issue_uses_rs2 = 0; reg_write = 0;
  endtask

  initial begin
`ifdef REG_BYPASS_EN
    byp = 1;
`else
    byp = 0;
`endif
    step();
    step();
    rst_n = 1;
    #1;
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      check($sformatf("reset_rs1_%0d", i), 64'(rs1_data), 64'h0);
      check($sformatf("reset_rs2_%0d", i), 64'(rs2_data), 64'h0);
    end
    check("reset_stall", 64'(stall), 64'h0);
    check("reset_cnt", 64'(pending_cnt), 64'h0);

    reg_write = 1; rd_addr = 5; write_data = 32'hDEADBEEF; rs1_addr = 5;
    #1;
    check("same_cycle_read_x5", 64'(rs1_data), byp ? 64'hDEADBEEF : 64'h0);
    step();
    rd_addr = 0; write_data = 32'h12345678;
    step();
    reg_write = 0; rs1_addr = 5; rs2_addr = 0;
    #1;
    check("read_x5", 64'(rs1_data), 64'hDEADBEEF);
    check("read_x0", 64'(rs2_data), 64'h0);

    issue(7);
    #1;
    check("issue7_no_stall", 64'(stall), 64'h0);
    step();
    check("cnt_after_issue7", 64'(pending_cnt), 64'h1);
    issue_wr = 0; issue_uses_rs1 = 1; rs1_addr = 7;
    #1;
    check("raw_stall_c1", 64'(stall), 64'h1);
    step();
    check("raw_stall_c2", 64'(stall), 64'h1);
    reg_write = 1; rd_addr = 7; write_data = 32'hCAFE0007;
    #1;
    check("raw_stall_wb_cycle", 64'(stall), byp ? 64'h0 : 64'h1);
    check("rs1_wb_cycle", 64'(rs1_data), byp ? 64'hCAFE0007 : 64'h0);
    step();
    reg_write = 0;
    #1;
    check("raw_stall_after_wb", 64'(stall), 64'h0);
    check("rs1_after_wb", 64'(rs1_data), 64'hCAFE0007);
    check("cnt_after_wb7", 64'(pending_cnt), 64'h0);
    idle();

    issue(9);
    step();
    check("cnt_after_issue9", 64'(pending_cnt), 64'h1);
    reg_write = 1; rd_addr = 9; write_data = 32'h99;
    issue(9);
    step();
    check("cnt_set_wins", 64'(pending_cnt), 64'h1);
    reg_write = 0; issue_wr = 0; issue_uses_rs1 = 1; rs1_addr = 9;
    #1;
    check("pending9_kept", 64'(stall), 64'h1);
    idle();
    reg_write = 1; rd_addr = 9; write_data = 32'h9999;
    step();
    reg_write = 0;
    check("cnt_after_wb9", 64'(pending_cnt), 64'h0);

    issue(12);
    step();
    check("cnt_after_issue12", 64'(pending_cnt), 64'h1);
    issue(10); issue_uses_rs2 = 1; rs2_addr = 12;
    #1;
    check("stall_rs2_pending", 64'(stall), 64'h1);
    step();
    check("cnt_stalled_issue", 64'(pending_cnt), 64'h1);
    issue_wr = 0; issue_uses_rs2 = 0; issue_uses_rs1 = 1; rs1_addr = 10;
    #1;
    check("pending10_not_set", 64'(stall), 64'h0);
    idle();

    issue(3);
    step();
    issue(4);
    step();
    check("cnt_before_reset", 64'(pending_cnt), 64'h3);
    issue(6); issue_wr = 0; issue_uses_rs2 = 1; rs2_addr = 3; rs1_addr = 5;
    #1;
    check("stall_before_reset", 64'(stall), 64'h1);
    check("x5_before_reset", 64'(rs1_data), 64'hDEADBEEF);
    #1;
    rst_n = 0;
    #1;
    check("async_cnt", 64'(pending_cnt), 64'h0);
    check("async_stall", 64'(stall), 64'h0);
    check("async_x5", 64'(rs1_data), 64'h0);
    rs1_addr = 7; rs2_addr = 9;
    #1;
    check("async_x7", 64'(rs1_data), 64'h0);
    check("async_x9", 64'(rs2_data), 64'h0);
    idle();
    step();
    rst_n = 1;
    step();
    check("cnt_after_release", 64'(pending_cnt), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
